// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display bus.
// Segment pattern constants (bit6=a ... bit0=g, 1 = lit) are also used by the
// display driver, so the encode and readback sides cannot drift apart.
package ssd_pkg;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h73;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  typedef enum logic {
    SYNC    = 1'b0,
    HAVE_LO = 1'b1
  } cap_state_t;

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational segment pattern to hex nibble decoder.
// Ports:
//   seg    in  7  segment pattern (bit6=a ... bit0=g)
//   nib    out 4  decoded nibble (0 when illegal)
//   legal  out 1  pattern is one of the sixteen hex glyphs
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nib,
  output logic       legal
);

  always_comb begin
    nib   = 4'h0;
    legal = 1'b1;
    case (seg)
      SEG_0:   nib = 4'h0;
      SEG_1:   nib = 4'h1;
      SEG_2:   nib = 4'h2;
      SEG_3:   nib = 4'h3;
      SEG_4:   nib = 4'h4;
      SEG_5:   nib = 4'h5;
      SEG_6:   nib = 4'h6;
      SEG_7:   nib = 4'h7;
      SEG_8:   nib = 4'h8;
      SEG_9:   nib = 4'h9;
      SEG_A:   nib = 4'hA;
      SEG_B:   nib = 4'hB;
      SEG_C:   nib = 4'hC;
      SEG_D:   nib = 4'hD;
      SEG_E:   nib = 4'hE;
      SEG_F:   nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_capture.sv
// Readback decoder for the two-digit multiplexed seven-segment bus.
// Recovers the displayed byte, flags illegal glyphs and a stalled multiplex.
// Ports:
//   clk      in   1  system clock
//   rst      in   1  asynchronous active-high reset
//   ssd      in   7  segment lines (bit6=a ... bit0=g)
//   ssdcat   in   1  cathode select (0 = low nibble, 1 = high nibble)
//   value    out  8  last complete frame {hi,lo}
//   valid    out  1  one-cycle pulse when value updates
//   bad_seg  out  1  one-cycle pulse on a qualified illegal pattern
//   err_cnt  out  8  saturating count of illegal patterns
//   stale    out  1  cathode has not toggled for TIMEOUT cycles
module ssd_capture #(
  parameter int STABLE_CYCLES = 1,
  parameter int TIMEOUT       = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] ssd,
  input  logic       ssdcat,
  output logic [7:0] value,
  output logic       valid,
  output logic       bad_seg,
  output logic [7:0] err_cnt,
  output logic       stale
);
  import ssd_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  logic [6:0]    r_ssd;
  logic          r_cat;
  logic [7:0]    run;
  logic          fired;
  logic [3:0]    lo;
  logic [TW-1:0] to_cnt, to_cnt_next;
  cap_state_t    state, state_next;

  logic       sample_new, cat_change, qual, to_hit;
  logic [3:0] nib;
  logic       legal;
  logic       val_load, lo_load, bad;

  ssd_seg_decode u_dec (
    .seg   (r_ssd),
    .nib   (nib),
    .legal (legal)
  );

  assign sample_new = ({ssd, ssdcat} != {r_ssd, r_cat});
  assign cat_change = (ssdcat != r_cat);

  // fired stops a run that saturates at 255 from re-qualifying every cycle
  assign qual = (run == 8'(STABLE_CYCLES)) && !fired;

  assign to_cnt_next = cat_change ? '0 :
                       (to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1;
  // one-shot: only the edge on which the counter first reaches TIMEOUT
  assign to_hit = (to_cnt != TO_MAX) && (to_cnt_next == TO_MAX);

  always_comb begin
    state_next = state;
    val_load   = 1'b0;
    lo_load    = 1'b0;
    bad        = 1'b0;
    if (qual) begin
      if (!legal) begin
        bad        = 1'b1;
        state_next = SYNC;
      end else if (!r_cat) begin
        lo_load    = 1'b1;
        state_next = HAVE_LO;
      end else if (state == HAVE_LO) begin
        val_load   = 1'b1;
        state_next = SYNC;
      end
    end
    if (to_hit) state_next = SYNC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ssd   <= '0;
      r_cat   <= 1'b0;
      run     <= '0;
      fired   <= 1'b0;
      lo      <= '0;
      state   <= SYNC;
      to_cnt  <= '0;
      stale   <= 1'b0;
      value   <= '0;
      valid   <= 1'b0;
      bad_seg <= 1'b0;
      err_cnt <= '0;
    end else begin
      r_ssd <= ssd;
      r_cat <= ssdcat;
      if (sample_new) begin
        run   <= 8'd1;
        fired <= 1'b0;
      end else begin
        if (run != 8'hFF) run <= run + 8'd1;
        if (qual) fired <= 1'b1;
      end
      state  <= state_next;
      to_cnt <= to_cnt_next;
      if (cat_change)  stale <= 1'b0;
      else if (to_hit) stale <= 1'b1;
      if (lo_load)  lo    <= nib;
      if (val_load) value <= {nib, lo};
      valid   <= val_load;
      bad_seg <= bad;
      if (bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: doc/ssd_capture.md
# ssd_capture

Readback decoder for the multiplexed two-digit seven-segment display bus. It samples the segment lines and cathode-select line driven to the display and recovers the displayed 8-bit value. It also flags illegal segment patterns and a stalled multiplex. It sits beside the display driver in the stopwatch controller and is used for self-check and register readback of what is actually shown.

## Interface
- STABLE_CYCLES, 1, consecutive identical samples needed before a sample is qualified (1..255)
- TIMEOUT, 1000, cycles without a cathode toggle before `stale` asserts (≥2)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- ssd  in  7  segment lines, bit6=a … bit0=g, 1 = lit
- ssdcat  in  1  cathode select: 0 = low nibble shown, 1 = high nibble shown
- value  out  8  last complete decoded frame {hi,lo}
- valid  out  1  one-cycle pulse when `value` updates
- bad_seg  out  1  one-cycle pulse on a qualified illegal pattern
- err_cnt  out  8  count of bad patterns, saturates at 255
- stale  out  1  high while cathode has not toggled for TIMEOUT cycles

## Operation
- Decode table (hex pattern→nibble): 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 73→9, 77→A, 1F→B, 4E→C, 3D→D, 4F→E, 47→F. Any other pattern is illegal.
- Input stage registers `ssd`/`ssdcat` into r_ssd/r_cat.
- run: 8-bit counter. Set to 1 when the new sample differs from {r_ssd,r_cat}, otherwise increment, saturating at 255.
- A sample is qualified in the cycle where run == STABLE_CYCLES, once per run. Shorter runs are ignored as glitches.
- FSM states:
  - SYNC: a qualified legal sample with r_cat=0 stores lo and moves to HAVE_LO. Other qualified samples do not change state.
  - HAVE_LO: a qualified legal sample with r_cat=1 sets value←{nib,lo}, pulses valid and returns to SYNC. A qualified legal sample with r_cat=0 overwrites lo and stays in HAVE_LO.
- Any qualified illegal sample, in either state, pulses bad_seg, increments err_cnt (saturating) and forces SYNC. It does not change value.
- Timeout counter:
  - Cleared on every r_cat change; otherwise increments, saturating at TIMEOUT.
  - On reaching TIMEOUT: stale←1 and FSM←SYNC.
  - stale clears on the next r_cat change.
- Simultaneous illegal sample and timeout: both take effect.

## Timing
- Reset values: value=0, valid=0, bad_seg=0, err_cnt=0, stale=0, FSM=SYNC, run=0, r_ssd=0, r_cat=0, timeout counter=0.
- Reset acts immediately, mid-frame included. A captured lo is discarded.
- A pattern first sampled at edge E qualifies during the cycle after edge E+STABLE_CYCLES−1. value/valid/bad_seg register at edge E+STABLE_CYCLES.
- With STABLE_CYCLES=1 and a cathode toggling every clock: one valid every 2 cycles, value lagging the high-phase input by 2 edges.
- stale sets at the TIMEOUT-th edge after the last r_cat change.
- valid and bad_seg are never high in the same cycle.

## Structure
- Shared package `ssd_pkg`:
  - SEG_0…SEG_F 7-bit pattern constants, shared with the display driver.
  - FSM state enum {SYNC, HAVE_LO}.
- Sub-module `ssd_seg_decode`: combinational 7-bit pattern → 4-bit nibble + legal flag, built from the package constants.

## Test plan
- STABLE=1, cathode toggling each cycle, lo=5B, hi=77 → value=0xA5, valid pulses every 2nd cycle, err_cnt=0.
- Frame lo=7E, hi=00 (illegal) → one bad_seg pulse, err_cnt=1, value unchanged. Next frame lo=30, hi=6D → value=0x21.
- STABLE=3, each phase held 6 cycles, 1-cycle 7F glitch inserted mid-phase → glitch ignored, value correct, err_cnt=0.
- TIMEOUT=16, ssdcat held at 1 → stale=1 at edge 16. Toggling resumes → stale=0 on the first change, and no valid until a full lo-then-hi frame.
- rst asserted in HAVE_LO, released, hi phase arrives first → no valid until the following lo,hi pair.
- 300 consecutive qualified illegal samples → err_cnt stops at 255 and bad_seg still pulses each time.
